int_dist: RTL
=============

// Module: int_dist
// PURPOSE
//  Multi-domain distributor: takes a DATA_W-bit word written in the clocks[0] domain and delivers it
//  to all CTR_NUMBER counter clock domains via a level req/ack 4-phase handshake. Each domain gets a
//  stable copy plus a one-cycle write strobe in its own clock. It is the counterpart of the
//  many-to-one snapshot synchronizer: it carries control/preset words from the master domain out to
//  the integer/fractional counters.
// PARAMETERS
//  CTR_NUMBER  1   number of destination clock domains (clocks[0] is also the source domain)
//  DATA_W      10  word width
// PORTS
//  clocks    in   CTR_NUMBER       clocks; clocks[0] is the master/source domain
//  rst       in   1                asynchronous reset, active-low, all domains
//  in_data   in   DATA_W           word to distribute (clocks[0])
//  in_wr     in   1                write strobe (clocks[0]); accepted only when busy=0
//  busy      out  1                transfer in progress (clocks[0])
//  done      out  1                one-cycle pulse: every domain has acked and released (clocks[0])
//  overrun   out  1                one-cycle pulse: in_wr seen while busy=1; word dropped (clocks[0])
//  out_data  out  DATA_W x CTR_NUMBER  unpacked array; out_data[i] in clocks[i] domain
//  out_wr    out  CTR_NUMBER       out_wr[i]: one-cycle clocks[i] pulse, out_data[i] updated same edge
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, hold=0, req=0, all sync flops 0, busy=0, done=0, overrun=0,
//   out_data[i]=0, out_wr[i]=0. Mid-transfer reset aborts; no out_wr is issued afterwards.
//  Master FSM (clocks[0]): IDLE -> REQ -> REL -> DONE -> IDLE.
//   IDLE: in_wr=1 -> hold<=in_data, req<=1, go REQ.
//   REQ : wait until all synced acks are 1 (&ack_s) -> req<=0, go REL.
//   REL : wait until all synced acks are 0 (~|ack_s) -> go DONE.
//   DONE: one cycle, then IDLE.
//   busy = (state!=IDLE); done = (state==DONE), Moore.
//   overrun registered: 1 for exactly one cycle after any edge where in_wr=1 and state!=IDLE.
//   hold is written only in IDLE and stays stable while req=1 or any ack is 1.
//  Destination i (clocks[i], including i=0 for uniform latency):
//   req_s[i] 2-flop synchronizer of req; req_d[i] = previous req_s[i][1].
//   rise = req_s[i][1] & ~req_d[i]: out_data[i]<=hold, out_wr[i]<=1; else out_wr[i]<=0.
//   ack[i] = req_s[i][1] (level, from flop); master syncs each ack through 2 clocks[0] flops.
//  Latency: in_wr sampled at clocks[0] edge N -> out_wr[i] high after the 3rd clocks[i] edge
//   following req rising (for i=0: out_wr[0] high after edge N+3). done at clocks[0] edge
//   N+2+(ack round trip); with all equal clocks, done is high after edge N+10.
//  out_wr[i] is pulsed exactly once per accepted in_wr; out_data[i] holds until the next capture.
//  in_wr in the DONE cycle is an overrun. The next word is accepted in the following IDLE cycle.
//  CTR_NUMBER=1 degenerates to a 2-flop round trip in clocks[0]; no special casing.
//  No combinational path from any input to any output.
// TESTING
//  1 CTR_NUMBER=3, clocks 10/13/27 ns; in_wr with in_data=10'h2A5 -> each out_wr[i] pulses once;
//    out_data[i]=10'h2A5; done pulses once; busy 1 from N+1 until done.
//  2 in_wr held high 20 cycles during transfer -> overrun pulses each busy cycle; exactly one
//    delivery of the first word.
//  3 Back-to-back: 10'h001, then 10'h3FF on the first IDLE cycle after done -> each domain sees
//    001 then 3FF, in order, no lost or duplicate out_wr.
//  4 All clocks equal (10 ns), CTR_NUMBER=1 -> out_wr[0] high after edge N+3; done high after
//    edge N+10.
//  5 rst pulsed low while in REQ with 2 of 3 domains captured -> all outputs 0 immediately;
//    no further out_wr; after release the next in_wr=10'h155 delivers normally.
//  6 Random words, random clock ratios 1:1 to 1:5, 1000 transfers -> scoreboard per domain matches
//    the accepted sequence; no X on outputs.

Source files
------------

// File: rtl/int_dist.sv
// Purpose: distributes a word from the clocks[0] domain to every counter clock domain via a 4-phase req/ack handshake.
// Latency: out_wr[i] rises on the 3rd clocks[i] edge after req rises (edge N+3 for domain 0); done follows the full ack round trip.
// Backpressure: busy stays high for the whole transfer; an in_wr seen while busy drops the word and pulses overrun.
module int_dist #(
  parameter int CTR_NUMBER = 1,
  parameter int DATA_W     = 10
) (
  input  logic [CTR_NUMBER-1:0] clocks,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_wr,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun,
  output logic [DATA_W-1:0]     out_data [CTR_NUMBER],
  output logic [CTR_NUMBER-1:0] out_wr
);

  typedef enum logic [1:0] {IDLE, REQ, REL, DONE} state_t;

  state_t                  state;
  logic [DATA_W-1:0]       hold;
  logic                    req;
  logic [CTR_NUMBER-1:0]   ack;
  logic [CTR_NUMBER-1:0]   ack_m;
  logic [CTR_NUMBER-1:0]   ack_s;

  // Master handshake FSM; hold only changes in IDLE so it is stable while any domain may sample it.
  always_ff @(posedge clocks[0] or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      hold  <= '0;
      req   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_wr) begin
            hold  <= in_data;
            req   <= 1'b1;
            busy  <= 1'b1;
            state <= REQ;
          end
        end
        REQ: begin
          if (&ack_s) begin
            req   <= 1'b0;
            state <= REL;
          end
        end
        REL: begin
          if (~|ack_s) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          req   <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Flag a write that arrived while a transfer (including its DONE cycle) was still in progress.
  always_ff @(posedge clocks[0] or negedge rst) begin
    if (!rst) begin
      overrun <= 1'b0;
    end else begin
      overrun <= in_wr & (state != IDLE);
    end
  end

  // Bring every destination's ack level back into the master domain.
  always_ff @(posedge clocks[0] or negedge rst) begin
    if (!rst) begin
      ack_m <= '0;
      ack_s <= '0;
    end else begin
      ack_m <= ack;
      ack_s <= ack_m;
    end
  end

  for (genvar i = 0; i < CTR_NUMBER; i++) begin : g_dst
    logic [1:0]        req_s;
    logic              req_d;
    logic              wr_r;
    logic [DATA_W-1:0] data_r;

    // Synchronize req, capture hold on its rising edge and strobe the local write once.
    always_ff @(posedge clocks[i] or negedge rst) begin
      if (!rst) begin
        req_s  <= '0;
        req_d  <= 1'b0;
        wr_r   <= 1'b0;
        data_r <= '0;
      end else begin
        req_s <= {req_s[0], req};
        req_d <= req_s[1];
        if (req_s[1] & ~req_d) begin
          data_r <= hold;
          wr_r   <= 1'b1;
        end else begin
          wr_r   <= 1'b0;
        end
      end
    end

    assign ack[i]      = req_s[1];
    assign out_wr[i]   = wr_r;
    assign out_data[i] = data_r;
  end

endmodule
